// File: rtl/mul_pipe_ctrl.sv
// Two-stage pipelined front end for the signed radix-4 Booth multiplier.
// Accepts RISC-V M-extension multiply requests (MUL/MULH/MULHSU/MULHU) over a
// valid/ready handshake, registers operands into S1, applies sign correction
// on the signed-only product, and holds the 32-bit result and tag in S2 for
// writeback under backpressure.
//
// Ports (mul_pipe_ctrl):
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   request valid
//   in_ready_o   request can be accepted this cycle (combinational)
//   op_i         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1_i/rs2_i  operands A/B
//   tag_i        destination tag
//   flush_i      drop in-flight and incoming requests
//   out_valid_o  result valid
//   out_ready_i  consumer accepts result
//   result_o     selected 32-bit result
//   tag_o        tag of result
//   busy_o       any stage holds an entry
//
// Ports (mul):
//   i_a, i_b     signed 32-bit operands
//   o_p          signed 64-bit product

// Combinational signed 32x32 radix-4 Booth multiplier.
module mul (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_p
);
    logic [63:0] w_a_ext;
    logic [32:0] w_bx;

    assign w_a_ext = {{32{i_a[31]}}, i_a};
    // Implicit b[-1] = 0 below the LSB for the first Booth digit.
    assign w_bx    = {i_b, 1'b0};

    // Sum of 16 Booth partial products, each digit in {-2,-1,0,+1,+2}.
    always_comb begin
        logic [63:0] pp;
        logic [63:0] acc;
        pp  = '0;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            case (w_bx[2*i +: 3])
                3'b001, 3'b010: pp = w_a_ext;
                3'b011:         pp = w_a_ext << 1;
                3'b100:         pp = -(w_a_ext << 1);
                3'b101, 3'b110: pp = -w_a_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2*i));
        end
        o_p = acc;
    end
endmodule

module mul_pipe_ctrl #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [31:0]      rs1_i,
    input  logic [31:0]      rs2_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);
    localparam int unsigned XLEN = 32;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    logic             r_s1_valid;
    logic [1:0]       r_s1_op;
    logic [XLEN-1:0]  r_s1_a;
    logic [XLEN-1:0]  r_s1_b;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [XLEN-1:0]  r_s2_result;
    logic [TAG_W-1:0] r_s2_tag;

    logic [2*XLEN-1:0] w_p;
    logic [XLEN-1:0]   w_ph;
    logic [XLEN-1:0]   w_pl;
    logic [XLEN-1:0]   w_result;
    logic              w_in_fire;
    logic              w_s2_load;

    mul u_mul (
        .i_a (r_s1_a),
        .i_b (r_s1_b),
        .o_p (w_p)
    );

    assign w_ph = w_p[2*XLEN-1:XLEN];
    assign w_pl = w_p[XLEN-1:0];

    // Unsigned views of the signed product: add back the operand whose
    // sign bit was interpreted as -2^31 instead of +2^31 (all mod 2^32).
    always_comb begin
        w_result = w_ph;
        case (r_s1_op)
            OP_MUL:    w_result = w_pl;
            OP_MULH:   w_result = w_ph;
            OP_MULHSU: w_result = w_ph + (r_s1_b[XLEN-1] ? r_s1_a : '0);
            default:   w_result = w_ph + (r_s1_a[XLEN-1] ? r_s1_b : '0)
                                       + (r_s1_b[XLEN-1] ? r_s1_a : '0);
        endcase
    end

    // Ready only drops when both stages are full and the output is stalled.
    assign in_ready_o = !flush_i && !(r_s1_valid && r_s2_valid && !out_ready_i);
    assign w_in_fire  = in_valid_i && in_ready_o;
    assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready_i);

    // Pipeline registers; reset beats flush beats handshakes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_tag    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_tag    <= '0;
        end else if (flush_i) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            // Accept with S1 full only happens when S1 also advances.
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= op_i;
                r_s1_a     <= rs1_i;
                r_s1_b     <= rs2_i;
                r_s1_tag   <= tag_i;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_load) begin
                r_s2_valid  <= 1'b1;
                r_s2_result <= w_result;
                r_s2_tag    <= r_s1_tag;
            end else if (out_ready_i) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o = r_s2_valid;
    assign result_o    = r_s2_result;
    assign tag_o       = r_s2_tag;
    assign busy_o      = r_s1_valid || r_s2_valid;
endmodule

// File: doc/mul_pipe_ctrl.md
# mul_pipe_ctrl

Two-stage pipelined front end for the combinational radix-4 Booth multiplier `mul` (signed 32x32 -> 64). It accepts RISC-V M-extension multiply requests over a valid/ready handshake and registers the operands into the multiplier. It applies sign correction so that all four multiply ops come from the signed-only core, and returns a registered 32-bit result with tag to the writeback stage under backpressure. It sits between the execute issue logic and writeback.

## Interface
- TAG_W, 5, width of the destination tag passed through unchanged
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset: synchronous, active-high
- in_valid_i  input  1  request valid
- in_ready_o  output  1  stage can accept a request this cycle
- op_i  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- rs1_i  input  32  operand A (signed for MULHSU)
- rs2_i  input  32  operand B (unsigned for MULHSU)
- tag_i  input  TAG_W  destination tag
- flush_i  input  1  drop all in-flight and incoming requests
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- result_o  output  32  selected result word
- tag_o  output  TAG_W  tag of result
- busy_o  output  1  any stage holds a valid entry

## Operation
- S1 register fields: s1_valid, op, a, b, tag. It loads on an input handshake (in_valid_i && in_ready_o).
- `mul` is instantiated with a/b from S1 and produces a signed 64-bit product P = {ph, pl}.
- Correction is applied combinationally between S1 and S2, with all sums taken mod 2^32:
  - MUL: result = pl.
  - MULH: result = ph.
  - MULHSU: result = ph + (b[31] ? a : 0).
  - MULHU: result = ph + (a[31] ? b : 0) + (b[31] ? a : 0).
- S2 register fields: s2_valid, result, tag. It drives out_valid_o, result_o and tag_o directly.
- Advance rules:
  - S2 loads from S1 when s1_valid && (!s2_valid || out_ready_i).
  - s2_valid clears on an output handshake when S1 has no entry to move in.
  - S1 clears when it advances and no new request is accepted.
- in_ready_o = !flush_i && !(s1_valid && s2_valid && !out_ready_i). This path from out_ready_i is combinational.
- Simultaneous accept, advance and retire in one cycle is legal and gives full throughput.
- busy_o = s1_valid || s2_valid.
- Flush behaviour:
  - While flush_i is high, no request is accepted.
  - After that edge, s1_valid = s2_valid = 0.
  - out_valid_o is not masked combinationally. An output handshake in the flush cycle counts as delivered.
- Ordering: results leave in acceptance order. No entry is dropped or duplicated, except by flush or reset.

## Timing
- Reset (rst_i high at edge):
  - s1_valid = s2_valid = 0.
  - out_valid_o = 0, result_o = 0, tag_o = 0, busy_o = 0.
  - All data registers are zero.
  - in_ready_o = 1 once rst_i is low (and flush_i is low).
- Reset mid-operation discards all entries, and no stale result appears afterwards. rst_i has priority over flush_i and all handshakes.
- Latency: a request accepted at edge N gives out_valid_o high after edge N+1, when the output is not stalled.
- Throughput: 1 request/cycle while out_ready_i is held high.
- Stall:
  - While out_valid_o && !out_ready_i, result_o and tag_o hold stable.
  - S1 holds its entry if S2 is occupied.
  - Capacity is 2 entries. in_ready_o drops only when both stages are full and the output is stalled.
- The multiplier path (`mul` plus correction adder) is the single-cycle critical path between the S1 and S2 registers.

## Test plan
- Op sweep with a = b = 0xFFFFFFFF -> MUL 0x00000001, MULH 0x00000000, MULHSU 0xFFFFFFFF, MULHU 0xFFFFFFFE. Each result arrives 2 edges after acceptance with its tag.
- a = b = 0x80000000 -> MULH 0x40000000, MULHU 0x40000000, MULHSU 0xC0000000, MUL 0x00000000. Also run a random signed/unsigned scoreboard of at least 10k ops against a 64-bit reference model.
- Streaming: 8 back-to-back requests with out_ready_i = 1 -> 8 consecutive out_valid_o cycles in order, and in_ready_o never low.
- Backpressure: hold out_ready_i = 0 and offer 4 requests -> exactly 2 accepted, then in_ready_o = 0. result_o/tag_o stay stable. After release, the results for tags 0,1,2,3 emerge in order with no loss.
- Flush with both stages full and a new request offered -> request not accepted, busy_o = 0 next cycle, no out_valid_o afterwards. A request issued after the flush completes normally.
- rst_i asserted with 2 entries in flight -> out_valid_o = 0, result_o = 0, tag_o = 0 after the edge. The first post-reset request yields only its own result.
